regfile_writeback: RTL
======================

// Module: regfile_writeback
// PURPOSE
//   Write-port driver for the 32-entry MIPS GPR file.
//   - Accepts results from two producers: the ALU and the load unit.
//   - Extracts and extends load bytes/halfwords.
//   - Buffers results in an in-order FIFO.
//   - Issues at most one GPR write per cycle on the Regwrite/write_register/write_data port.
//   - Exports a pending-write scoreboard for hazard detection.
// PARAMETERS
//   DEPTH  4                     FIFO entries; power of 2, >=2
//   PTR_W  $clog2(DEPTH)         pointer width (derived, do not override)
// PORTS
//   clk             in   1   clock
//   reset           in   1   synchronous, active-high reset
//   alu_valid       in   1   ALU result valid
//   alu_ready       out  1   ALU result accepted this cycle
//   alu_rd          in   5   ALU destination GPR index
//   alu_data        in   32  ALU result
//   ld_valid        in   1   load result valid
//   ld_ready        out  1   load result accepted this cycle
//   ld_rd           in   5   load destination GPR index
//   ld_word         in   32  raw aligned memory word
//   ld_size         in   2   00 byte, 01 half, 10/11 word
//   ld_signed       in   1   1 = sign-extend, 0 = zero-extend
//   ld_offset       in   2   byte address bits [1:0]
//   stall           in   1   1 = write port must not issue this cycle
//   Regwrite        out  1   GPR write enable
//   write_register  out  5   GPR write index
//   write_data      out  32  GPR write data
//   pending         out  32  bit r set while any queued entry targets GPR r
//   occupancy       out  PTR_W+1  current FIFO entry count
// BEHAVIOUR
//   Reset:
//     - FIFO emptied and occupancy=0.
//     - Regwrite=0, write_register=0, write_data=0, pending=0.
//     - alu_ready=0, ld_ready=0 while reset is high.
//     - Reset mid-operation discards every queued entry; no write issues in the cycle after reset.
//   Handshake: a transfer occurs on a cycle with valid&ready high and is sampled at the clock edge.
//     - ld_ready  = !reset & !full
//     - alu_ready = !reset & !full & !ld_valid   (load has priority; at most one push per cycle)
//     - full blocks a push even if a pop occurs in the same cycle.
//   $0 handling: a transfer with rd==0 completes the handshake but is discarded.
//     - No FIFO push, no write, no pending bit.
//   Load extraction (little-endian):
//     - byte: ld_word[8*ld_offset +: 8]
//     - half: ld_offset[1] ? ld_word[31:16] : ld_word[15:0]; ld_offset[0] ignored
//     - word: ld_word as-is; ld_signed ignored
//     - Byte/half results extend to 32 bits per ld_signed.
//   Write port (combinational from FIFO head):
//     - Regwrite = !empty & !stall.
//     - write_register/write_data = head entry when Regwrite=1, else 0.
//     - Pop on every cycle with Regwrite=1.
//     - Minimum latency: accepted in cycle k -> written in cycle k+1.
//   Ordering: strict FIFO order across both producers; same-rd writes are never reordered.
//   Pointers: read/write pointers wrap modulo DEPTH; full = occupancy==DEPTH.
//     - Push and pop in the same cycle leave occupancy unchanged.
//   pending: OR over valid entries of (1<<rd); recomputed each cycle; excludes the entry being bypassed.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     - When FIFO empty, stall=0, and a non-$0 transfer occurs, the write port drives that entry
//       in the same cycle (zero latency). The entry is not enqueued.
//   WB_BYPASS_EN undefined: every entry passes through the FIFO; minimum latency 1 cycle.
// TESTING
//   1 ALU rd=2 data=0xDEADBEEF for one cycle after reset
//       -> next cycle: Regwrite=1, write_register=2, write_data=0xDEADBEEF.
//       -> pending[2]=1 in that cycle, 0 in the following cycle.
//   2 Loads with ld_word=0x80FF1234
//       -> byte/signed/off3 gives 0xFFFFFF80; half/unsigned/off2 gives 0x000080FF;
//          byte/unsigned/off1 gives 0x00000012.
//   3 alu_valid (rd=3) and ld_valid (rd=3) in the same cycle
//       -> ld_ready=1, alu_ready=0; ALU accepted next cycle.
//       -> Writes issue in order: load data, then ALU data.
//   4 stall=1 with 4 ALU pushes (rd=4..7)
//       -> occupancy=4, alu_ready=0, 5th held, pending=0xF0.
//       -> stall=0: four consecutive writes rd 4,5,6,7, then 5th accepted.
//   5 ALU rd=0 data=0x1
//       -> alu_ready=1, Regwrite stays 0, occupancy stays 0, pending=0.
//   6 3 entries queued under stall, then reset pulsed
//       -> cycle after reset: Regwrite=0, occupancy=0, pending=0.
//       -> WB_BYPASS_EN build: test 1 write appears in the acceptance cycle.

Source files
------------

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_writeback_if
//  Purpose  : Bundles the producer handshakes (ALU and load unit), the stall
//             input and the GPR write-port / scoreboard outputs of
//             regfile_writeback.
//  Modports : slave  - the writeback block (consumes results, drives port)
//             master - the surrounding pipeline / testbench
//  Signals  : alu_valid/alu_ready/alu_rd/alu_data      ALU result channel
//             ld_valid/ld_ready/ld_rd/ld_word/ld_size/
//             ld_signed/ld_offset                      load result channel
//             stall                                    write-port hold
//             Regwrite/write_register/write_data       GPR write port
//             pending                                  per-GPR pending bits
//             occupancy                                FIFO entry count
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_writeback_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic               alu_valid;
    logic               alu_ready;
    logic [4:0]         alu_rd;
    logic [31:0]        alu_data;

    logic               ld_valid;
    logic               ld_ready;
    logic [4:0]         ld_rd;
    logic [31:0]        ld_word;
    logic [1:0]         ld_size;
    logic               ld_signed;
    logic [1:0]         ld_offset;

    logic               stall;

    logic               Regwrite;
    logic [4:0]         write_register;
    logic [31:0]        write_data;
    logic [31:0]        pending;
    logic [PTR_W:0]     occupancy;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_word, ld_size, ld_signed, ld_offset,
        input  stall,
        output alu_ready, ld_ready,
        output Regwrite, write_register, write_data, pending, occupancy
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_word, ld_size, ld_signed, ld_offset,
        output stall,
        input  alu_ready, ld_ready,
        input  Regwrite, write_register, write_data, pending, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_writeback
//  Purpose  : Write-port driver for the 32-entry MIPS GPR file. Accepts
//             results from the ALU and the load unit (load has priority),
//             extracts/extends load bytes and halfwords, queues results in an
//             in-order FIFO and issues at most one GPR write per cycle.
//             Exports a pending-write scoreboard for hazard detection.
//  Ports    : clk    - clock
//             reset  - synchronous, active-high reset
//             wb     - regfile_writeback_if.slave (producers, stall, write
//                      port, pending, occupancy)
//  Options  : WB_BYPASS_EN - when defined, a result arriving while the FIFO
//             is empty and the port is not stalled is written in the same
//             cycle instead of being enqueued.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    regfile_writeback_if.slave  wb
);
    localparam int PTR_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Load data extraction (little-endian lanes)
    // ------------------------------------------------------------------
    function automatic logic [31:0] ld_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]       rd_mem_q   [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q,    vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // ------------------------------------------------------------------
    // Handshake and input selection
    // ------------------------------------------------------------------
    logic        full, empty;
    logic        ld_fire, alu_fire, in_fire;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        keep, bypass, push, pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    assign wb.ld_ready  = ~reset & ~full;
    assign wb.alu_ready = ~reset & ~full & ~wb.ld_valid;

    assign ld_fire  = wb.ld_valid  & wb.ld_ready;
    assign alu_fire = wb.alu_valid & wb.alu_ready;
    assign in_fire  = ld_fire | alu_fire;

    // Readies are mutually exclusive, so at most one source fires.
    assign in_rd   = ld_fire ? wb.ld_rd : wb.alu_rd;
    assign in_data = ld_fire ? ld_extract(wb.ld_word, wb.ld_size,
                                          wb.ld_signed, wb.ld_offset)
                             : wb.alu_data;

    // Writes to $0 complete the handshake and are then dropped.
    assign keep = in_fire & (in_rd != 5'd0);

`ifdef WB_BYPASS_EN
    // An empty queue means no older write can be overtaken.
    assign bypass = keep & empty & ~wb.stall;
`else
    assign bypass = 1'b0;
`endif

    assign push = keep & ~bypass;
    assign pop  = ~reset & ~empty & ~wb.stall;

    // ------------------------------------------------------------------
    // Write port (combinational from FIFO head or bypassed input)
    // ------------------------------------------------------------------
    always_comb begin
        wb.Regwrite       = 1'b0;
        wb.write_register = 5'd0;
        wb.write_data     = 32'd0;
        if (bypass) begin
            wb.Regwrite       = 1'b1;
            wb.write_register = in_rd;
            wb.write_data     = in_data;
        end else if (pop) begin
            wb.Regwrite       = 1'b1;
            wb.write_register = rd_mem_q[rd_ptr_q];
            wb.write_data     = data_mem_q[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: one bit per GPR targeted by any queued entry
    // ------------------------------------------------------------------
    always_comb begin
        wb.pending = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                wb.pending[rd_mem_q[i]] = 1'b1;
            end
        end
        if (reset) begin
            wb.pending = 32'd0;
        end
    end

    assign wb.occupancy = count_q;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        // Push and pop never target the same slot: pop needs a non-empty
        // queue and push needs a non-full one.
        if (pop) begin
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
            vld_d[rd_ptr_q]  = 1'b0;
        end
        if (push) begin
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            vld_d[wr_ptr_q]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= in_rd;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
`default_nettype wire
